debounce_multi: RTL and testbench



---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_chan.sv | 109 ++++++++++
 rtl/debounce_multi.sv | 62 ++++++
 tb/tb_debounce_multi.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared width helper and 50 MHz board timing defaults for the multi-channel debouncer.
package debounce_pkg;

    localparam int DB_CLK_DIV      = 1000;   // 20 us sample tick at 50 MHz
    localparam int DB_STABLE_10MS  = 500;
    localparam int DB_LONG_500MS   = 25000;
    localparam int DB_REPEAT_100MS = 5000;

    // Bits needed to hold 0..x, never narrower than one bit so a zero terminal value stays legal.
    function automatic int cnt_width(input int x);
        return (x < 1) ? 1 : $clog2(x + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer, tick-based stability filter,
// registered edge pulses and long-press / auto-repeat detection.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   STABLE_TICKS = DB_STABLE_10MS,
    parameter int   LONG_TICKS   = DB_LONG_500MS,
    parameter int   REPEAT_TICKS = DB_REPEAT_100MS,
    parameter logic RST_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic noisy,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic long_press,
    output logic rpt,
    output logic held
);

    localparam int SW = cnt_width(STABLE_TICKS);
    localparam int HW = cnt_width(LONG_TICKS);
    localparam int RW = cnt_width(REPEAT_TICKS);

    localparam logic [SW-1:0] S_END = SW'(STABLE_TICKS);
    localparam logic [SW-1:0] S_ONE = SW'(1);
    localparam logic [HW-1:0] H_END = HW'(LONG_TICKS);
    localparam logic [HW-1:0] H_ONE = HW'(1);
    localparam logic [RW-1:0] R_END = RW'(REPEAT_TICKS);
    localparam logic [RW-1:0] R_ONE = RW'(1);

    logic          sync1;
    logic          sync2;
    logic          xnew;
    logic [SW-1:0] scnt;
    logic [HW-1:0] hcnt;
    logic [RW-1:0] rcnt;
    logic          settle;
    logic          drop;

    // clean takes xnew on the tick that completes the stability window
    assign settle = (sync2 == xnew) && tick && (scnt < S_END) &&
                    (scnt + S_ONE == S_END) && (xnew != clean);
    assign drop   = settle && !xnew;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RST_LEVEL;
            sync2 <= RST_LEVEL;
            xnew  <= RST_LEVEL;
            clean <= RST_LEVEL;
            scnt  <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= noisy;
            sync2 <= sync1;
            rise  <= settle && xnew;
            fall  <= drop;
            if (sync2 != xnew) begin
                xnew <= sync2;
                scnt <= '0;
            end else if (tick && (scnt < S_END)) begin
                scnt <= scnt + S_ONE;
            end
            if (settle) begin
                clean <= xnew;
            end
        end
    end

    // Hold timing runs only while clean is high; the falling settle cancels any pulse due on that tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt       <= '0;
            rcnt       <= '0;
            long_press <= 1'b0;
            rpt        <= 1'b0;
            held       <= 1'b0;
        end else begin
            long_press <= 1'b0;
            rpt        <= 1'b0;
            if (!clean || drop) begin
                hcnt <= '0;
                rcnt <= '0;
                held <= 1'b0;
            end else if (tick) begin
                if (hcnt < H_END) begin
                    hcnt <= hcnt + H_ONE;
                    if (hcnt + H_ONE == H_END) begin
                        long_press <= 1'b1;
                        held       <= 1'b1;
                    end
                end
                if ((REPEAT_TICKS > 0) && held) begin
                    if (rcnt + R_ONE == R_END) begin
                        rpt  <= 1'b1;
                        rcnt <= '0;
                    end else begin
                        rcnt <= rcnt + R_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel button/switch conditioner: one shared sample-tick prescaler
// feeding NCH independent debounce channels.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int             NCH          = 4,
    parameter int             CLK_DIV      = DB_CLK_DIV,
    parameter int             STABLE_TICKS = DB_STABLE_10MS,
    parameter int             LONG_TICKS   = DB_LONG_500MS,
    parameter int             REPEAT_TICKS = DB_REPEAT_100MS,
    parameter logic [NCH-1:0] RST_LEVEL    = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] noisy,
    output logic [NCH-1:0] clean,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] long_press,
    output logic [NCH-1:0] rpt,
    output logic [NCH-1:0] held
);

    localparam int            PW    = cnt_width(CLK_DIV - 1);
    localparam logic [PW-1:0] P_END = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    logic [PW-1:0] pcnt;
    logic          tick;

    // With CLK_DIV == 1 the count is pinned at zero and tick stays high.
    assign tick = (pcnt == P_END);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + P_ONE;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        debounce_chan #(
            .STABLE_TICKS(STABLE_TICKS),
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS),
            .RST_LEVEL   (RST_LEVEL[i])
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .noisy     (noisy[i]),
            .clean     (clean[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .long_press(long_press[i]),
            .rpt       (rpt[i]),
            .held      (held[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: a repeat-enabled and a repeat-disabled build side by side,
// checked every cycle against a tick-arithmetic reference plus directed corner sequences.
module tb_debounce_multi;

    localparam int         D  = 4;
    localparam int         ST = 3;
    localparam int         LT = 10;
    localparam int         RT = 5;
    localparam logic [1:0] RL = 2'b00;

    logic       clk = 1'b0;
    logic       rst;
    logic       chk_en = 1'b0;
    logic [1:0] noisy;
    logic [1:0] clean_a, rise_a, fall_a, long_a, rpt_a, held_a;
    logic [1:0] clean_b, rise_b, fall_b, long_b, rpt_b, held_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    debounce_multi #(.NCH(2), .CLK_DIV(D), .STABLE_TICKS(ST), .LONG_TICKS(LT),
                     .REPEAT_TICKS(RT), .RST_LEVEL(RL)) dut_a (
        .clk(clk), .rst(rst), .noisy(noisy), .clean(clean_a), .rise(rise_a), .fall(fall_a),
        .long_press(long_a), .rpt(rpt_a), .held(held_a));

    debounce_multi #(.NCH(2), .CLK_DIV(D), .STABLE_TICKS(ST), .LONG_TICKS(LT),
                     .REPEAT_TICKS(0), .RST_LEVEL(RL)) dut_b (
        .clk(clk), .rst(rst), .noisy(noisy), .clean(clean_b), .rise(rise_b), .fall(fall_b),
        .long_press(long_b), .rpt(rpt_b), .held(held_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: edges are numbered from reset release, a tick falls on every edge e with e%D==0,
    // so the ticks between edges a and b are b/D - a/D.
    int         m_e;
    logic [1:0] m_d1, m_d2, m_xv, m_clean, m_rise, m_fall;
    int         m_c [2];
    int         m_r [2];
    logic [1:0] m_long [2];
    logic [1:0] m_rpt  [2];
    logic [1:0] m_held [2];

    always @(posedge clk) begin
        logic [1:0] s;
        logic       tk;
        int         h;
        int         rep;
        if (rst) begin
            m_e = 0; m_d1 = RL; m_d2 = RL; m_xv = RL; m_clean = RL;
            m_rise = 2'b00; m_fall = 2'b00; tk = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                m_c[ch] = 0;
                m_r[ch] = 0;
            end
        end else begin
            m_e++;
            s = m_d2; m_d2 = m_d1; m_d1 = noisy;
            tk = (m_e % D == 0);
            m_rise = 2'b00; m_fall = 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                if (s[ch] != m_xv[ch]) begin
                    m_xv[ch] = s[ch];
                    m_c[ch]  = m_e;
                end else if (tk && (m_e / D - m_c[ch] / D) == ST && m_xv[ch] != m_clean[ch]) begin
                    m_clean[ch] = m_xv[ch];
                    m_rise[ch]  = m_xv[ch];
                    m_fall[ch]  = ~m_xv[ch];
                    m_r[ch]     = m_e;
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            rep = (d == 0) ? RT : 0;
            for (int ch = 0; ch < 2; ch++) begin
                h = m_e / D - m_r[ch] / D;
                m_held[d][ch] = m_clean[ch] && (h >= LT);
                m_long[d][ch] = m_clean[ch] && tk && (h == LT);
                m_rpt[d][ch]  = m_clean[ch] && tk && (rep > 0) && (h > LT) && ((h - LT) % rep == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_a", 32'({clean_a, rise_a, fall_a, long_a, rpt_a, held_a}),
                  32'({m_clean, m_rise, m_fall, m_long[0], m_rpt[0], m_held[0]}));
            check("cycle_b", 32'({clean_b, rise_b, fall_b, long_b, rpt_b, held_b}),
                  32'({m_clean, m_rise, m_fall, m_long[1], m_rpt[1], m_held[1]}));
        end
    end

    typedef struct {
        logic       rst;
        logic [1:0] noisy;
        int         cycles;
        logic [1:0] exp_clean;
        logic [1:0] exp_held;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int lat, cnt, bad, h, r0, f1;
        bit found;
        int qla[$], qra[$], qlb[$], qrb[$];

        tbl[0] = '{1'b1, 2'b00,  4, 2'b00, 2'b00};
        tbl[1] = '{1'b0, 2'b00, 20, 2'b00, 2'b00};
        tbl[2] = '{1'b0, 2'b11, 20, 2'b11, 2'b00};
        tbl[3] = '{1'b0, 2'b11, 40, 2'b11, 2'b11};
        tbl[4] = '{1'b0, 2'b01, 20, 2'b01, 2'b01};
        tbl[5] = '{1'b1, 2'b01,  1, 2'b00, 2'b00};
        tbl[6] = '{1'b0, 2'b00, 20, 2'b00, 2'b00};

        rst = 1'b1; noisy = 2'b00;
        @(negedge clk);
        chk_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].rst; noisy = tbl[i].noisy;
            repeat (tbl[i].cycles) @(negedge clk);
            check($sformatf("tbl%0d_clean", i), 32'(clean_a), 32'(tbl[i].exp_clean));
            check($sformatf("tbl%0d_held", i), 32'(held_a), 32'(tbl[i].exp_held));
        end

        // Reset release with both inputs already high.
        rst = 1'b1; noisy = 2'b11; bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rise_a != 2'b00 || fall_a != 2'b00 || clean_a != 2'b00) bad++;
        end
        check("t1_quiet_in_reset", 32'(bad), 32'(0));
        rst = 1'b0; lat = 0; cnt = 0; bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (clean_a == 2'b11 && lat == 0) lat = k;
            if (clean_a == 2'b01 || clean_a == 2'b10) bad++;
            if (rise_a == 2'b11) cnt++;
            else if (rise_a != 2'b00) bad++;
        end
        check("t1_latency_in_12_15", 32'(lat >= 12 && lat <= 15), 32'(1));
        check("t1_single_rise", 32'(cnt), 32'(1));
        check("t1_no_split_channels", 32'(bad), 32'(0));

        // Bounce rejection on channel 0.
        rst = 1'b1; noisy = 2'b00;
        @(negedge clk);
        rst = 1'b0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            noisy[0] = ~noisy[0];
            repeat (5) begin
                @(negedge clk);
                if (clean_a[0] || rise_a[0] || fall_a[0]) bad++;
            end
        end
        check("t2_bounce_rejected", 32'(bad), 32'(0));
        noisy[0] = 1'b1; lat = 0; cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (rise_a[0]) begin
                cnt++;
                if (lat == 0) lat = k;
            end
        end
        check("t2_rise_count", 32'(cnt), 32'(1));
        check("t2_latency_in_12_15", 32'(lat >= 12 && lat <= 15), 32'(1));

        // Long press with repeat (dut_a) and without repeat (dut_b) on channel 1.
        noisy[1] = 1'b1; found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (rise_a[1]) found = 1'b1;
        end
        check("t3_rise_seen", 32'(found), 32'(1));
        h = 0; bad = 0;
        for (int k = 0; k < 250 && h < 40; k++) begin
            @(negedge clk);
            if (m_e % D == 0) h++;
            if (long_a[1]) qla.push_back(h);
            if (rpt_a[1])  qra.push_back(h);
            if (long_b[1]) qlb.push_back(h);
            if (rpt_b[1])  qrb.push_back(h);
            if (held_a[1] != (h >= LT) || held_b[1] != (h >= LT)) bad++;
        end
        check("t3_hold_ticks_reached", 32'(h), 32'(40));
        check("t3_held_window", 32'(bad), 32'(0));
        check("t3_long_count_a", 32'(qla.size()), 32'(1));
        check("t3_long_tick_a", 32'((qla.size() > 0) ? qla[0] : -1), 32'(LT));
        check("t3_rpt_count_a", 32'(qra.size()), 32'(6));
        for (int i = 0; i < 6; i++)
            check($sformatf("t3_rpt%0d_tick_a", i), 32'((qra.size() > i) ? qra[i] : -1), 32'(LT + RT * (i + 1)));
        check("t6_long_count_b", 32'(qlb.size()), 32'(1));
        check("t6_long_tick_b", 32'((qlb.size() > 0) ? qlb[0] : -1), 32'(LT));
        check("t6_rpt_never_b", 32'(qrb.size()), 32'(0));
        check("t6_held_b", 32'(held_b[1]), 32'(1));

        noisy[1] = 1'b0; found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (fall_a[1]) begin
                found = 1'b1;
                check("t3_held_clear_at_fall", 32'({held_a[1], held_b[1]}), 32'(0));
            end
        end
        check("t3_fall_seen", 32'(found), 32'(1));
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (long_a[1] || rpt_a[1] || long_b[1] || rpt_b[1] || fall_a[1]) cnt++;
        end
        check("t3_quiet_after_release", 32'(cnt), 32'(0));

        // Simultaneous rise on ch0 and fall on ch1.
        noisy = 2'b10;
        repeat (30) @(negedge clk);
        noisy = 2'b01; r0 = 0; f1 = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (rise_a[0] && r0 == 0) r0 = k;
            if (fall_a[1] && f1 == 0) f1 = k;
        end
        check("t4_rise0_seen", 32'(r0 > 0), 32'(1));
        check("t4_same_cycle", 32'(f1), 32'(r0));

        // Reset in the middle of a held press.
        found = 1'b0;
        for (int k = 0; k < 80 && !found; k++) begin
            @(negedge clk);
            if (held_a[0]) found = 1'b1;
        end
        check("t5_held_reached", 32'(found), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        check("t5_clean_after_rst", 32'(clean_a), 32'(0));
        check("t5_held_after_rst", 32'(held_a), 32'(0));
        check("t5_no_fall_pulse", 32'(fall_a), 32'(0));
        rst = 1'b0; noisy = 2'b00;
        repeat (20) @(negedge clk);
        noisy = 2'b01; lat = 0; cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (rise_a[0]) begin
                cnt++;
                if (lat == 0) lat = k;
            end
        end
        check("t5_repress_rise_count", 32'(cnt), 32'(1));
        check("t5_repress_latency", 32'(lat >= 12 && lat <= 15), 32'(1));

        // Random runs: glitches, short and long holds, occasional reset.
        for (int s = 0; s < 150; s++) begin
            rst   = ($urandom_range(0, 39) == 0);
            noisy = 2'($urandom);
            if (rst) lat = 1;
            else if ($urandom_range(0, 7) == 0) lat = $urandom_range(60, 200);
            else lat = $urandom_range(1, 30);
            repeat (lat) @(negedge clk);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
